// File: rtl/qam_nibble_packer.sv
// Purpose: finds a sync byte in the demapped nibble stream, packs payload nibble pairs into bytes, and queues the bytes in a FIFO.
// Latency: a byte is visible on byte_out one edge after its second nibble is accepted, when the FIFO was empty (head is first-word fall-through).
// Backpressure: upstream has none. When the FIFO is full and nothing pops, the new byte is dropped and the sticky overflow flag is set.
module qam_nibble_packer #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         PAYLOAD_LEN = 16,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         LEVEL_W     = 4
) (
  input  logic               symbol_clock,
  input  logic               rst,
  input  logic [3:0]         sym_in,
  input  logic               sym_valid,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               locked,
  output logic               frame_start,
  output logic               overflow,
  input  logic               clr_overflow,
  output logic [LEVEL_W-1:0] fifo_level
);

  localparam int                 AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0]         LAST_IDX = 8'(PAYLOAD_LEN - 1);
  localparam logic [LEVEL_W-1:0] DEPTH_L  = LEVEL_W'(FIFO_DEPTH);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Framing state
  state_e     state_q, state_d;
  logic [3:0] prev_nib_q, prev_nib_d;   // older half of the hunt window
  logic [3:0] hi_q, hi_d;               // high nibble of the byte in progress
  logic       phase_q, phase_d;         // 1 once the high nibble is held
  logic [7:0] cnt_q, cnt_d;             // payload bytes completed this frame
  logic       locked_q, locked_d;
  logic       frame_start_q, frame_start_d;

  // Packer to FIFO handoff
  logic       push_req;
  logic [7:0] push_dat;

  // FIFO state
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               fifo_empty, fifo_full;
  logic               pop, push_ok, drop;

  // Next-state for hunt/lock framing and the nibble pairing; only valid symbols advance it
  always_comb begin
    state_d       = state_q;
    prev_nib_d    = prev_nib_q;
    hi_d          = hi_q;
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    frame_start_d = 1'b0;
    push_req      = 1'b0;
    push_dat      = {hi_q, sym_in};
    if (sym_valid) begin
      case (state_q)
        HUNT: begin
          if ({prev_nib_q, sym_in} == SYNC_BYTE) begin
            state_d       = LOCKED;
            prev_nib_d    = 4'h0;
            frame_start_d = 1'b1;
          end else begin
            prev_nib_d = sym_in;
          end
        end
        LOCKED: begin
          if (!phase_q) begin
            hi_d    = sym_in;
            phase_d = 1'b1;
          end else begin
            // A dropped byte still counts, so frame boundaries stay aligned.
            push_req = 1'b1;
            phase_d  = 1'b0;
            if (cnt_q == LAST_IDX) begin
              cnt_d   = 8'd0;
              state_d = HUNT;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  // FIFO control: a pop frees a slot on the same edge, so push-on-full with pop is accepted
  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == DEPTH_L);
    pop        = !fifo_empty && byte_ready;
    push_ok    = push_req && (!fifo_full || pop);
    drop       = push_req && fifo_full && !pop;
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + LEVEL_W'(1);
    end else if (pop && !push_ok) begin
      level_d = level_q - LEVEL_W'(1);
    end
    // A new drop wins over a same-cycle clear.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // All control state, including the registered FSM outputs, with async reset
  always_ff @(posedge symbol_clock or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      prev_nib_q    <= 4'h0;
      hi_q          <= 4'h0;
      phase_q       <= 1'b0;
      cnt_q         <= 8'd0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_nib_q    <= prev_nib_d;
      hi_q          <= hi_d;
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage array; contents are don't-care until written, since the pointers define what is live
  always_ff @(posedge symbol_clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  // Fall-through head, forced to zero when empty so reset and idle read back as 0
  always_comb begin
    byte_valid  = !fifo_empty;
    byte_out    = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    locked      = locked_q;
    frame_start = frame_start_q;
    overflow    = overflow_q;
    fifo_level  = level_q;
  end

endmodule

// File: tb/tb_qam_nibble_packer.sv
// Self-checking bench for qam_nibble_packer: directed scenarios plus randomized traffic
// against a queue-based reference model, compared on every falling edge.
module tb_qam_nibble_packer;

  localparam int         LEN   = 10;
  localparam int         DEPTH = 8;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sym_in = 4'h0;
  logic       sym_valid = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready = 1'b0;
  logic       locked;
  logic       frame_start;
  logic       overflow;
  logic       clr_overflow = 1'b0;
  logic [3:0] fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qam_nibble_packer #(
    .SYNC_BYTE  (SYNC),
    .PAYLOAD_LEN(LEN),
    .FIFO_DEPTH (DEPTH),
    .LEVEL_W    (4)
  ) dut (
    .symbol_clock(clk),
    .rst         (rst),
    .sym_in      (sym_in),
    .sym_valid   (sym_valid),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .locked      (locked),
    .frame_start (frame_start),
    .overflow    (overflow),
    .clr_overflow(clr_overflow),
    .fifo_level  (fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the last hunt nibble, a lock flag, a pending high nibble,
  // a byte counter, and the FIFO as a plain queue.
  int         m_prev, m_hi, m_cnt;
  bit         m_locked, m_have_hi, m_ovf, m_fs;
  logic [7:0] m_q [$];

  always @(posedge clk or posedge rst) begin
    bit pop_now, drop_now;
    if (rst) begin
      m_prev = 0; m_hi = 0; m_cnt = 0;
      m_locked = 0; m_have_hi = 0; m_ovf = 0; m_fs = 0;
      m_q.delete();
    end else begin
      pop_now  = (m_q.size() != 0) && byte_ready;
      drop_now = 0;
      m_fs     = 0;
      if (pop_now) void'(m_q.pop_front());
      if (sym_valid) begin
        if (!m_locked) begin
          if (m_prev * 16 + int'(sym_in) == int'(SYNC)) begin
            m_locked = 1; m_fs = 1; m_prev = 0;
          end else begin
            m_prev = int'(sym_in);
          end
        end else if (!m_have_hi) begin
          m_hi = int'(sym_in); m_have_hi = 1;
        end else begin
          m_have_hi = 0;
          if (m_q.size() < DEPTH) m_q.push_back(8'(m_hi * 16 + int'(sym_in)));
          else drop_now = 1;
          m_cnt++;
          if (m_cnt == LEN) begin m_cnt = 0; m_locked = 0; end
        end
      end
      if (drop_now) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_byte_valid", byte_valid, m_q.size() != 0);
      chk("m_byte_out", byte_out, (m_q.size() != 0) ? m_q[0] : 8'h00);
      chk("m_locked", locked, m_locked);
      chk("m_frame_start", frame_start, m_fs);
      chk("m_overflow", overflow, m_ovf);
      chk("m_fifo_level", fifo_level, m_q.size());
    end
  end

  task automatic send(input logic [3:0] n);
    sym_in = n; sym_valid = 1'b1;
    @(posedge clk); #1;
    sym_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b [8];
    int r;
    int rdy_pct;

    // Reset state
    idle(2);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_locked", locked, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fifo_level", fifo_level, 0);
    rst = 1'b0;

    // Hunt: 3,A,5 locks on the 5; byte 12 one cycle after nibble 2
    byte_ready = 1'b1;
    send(4'h3); send(4'hA);
    chk("hunt_no_lock_yet", locked, 0);
    send(4'h5);
    chk("hunt_frame_start", frame_start, 1);
    chk("hunt_locked", locked, 1);
    send(4'h1);
    chk("hunt_fs_pulse_end", frame_start, 0);
    chk("hunt_no_byte_yet", byte_valid, 0);
    send(4'h2);
    chk("hunt_byte_valid", byte_valid, 1);
    chk("hunt_byte_12", byte_out, 8'h12);
    chk("hunt_level_1", fifo_level, 1);

    // Frame end: 9 more bytes complete the frame; the last one is 8'h01
    for (int i = 0; i < 18; i++) send(4'(i));
    chk("end_locked_drop", locked, 0);
    chk("end_last_byte", byte_out, 8'h01);
    send(4'h5); send(4'h6);
    idle(1);
    chk("end_discard_level", fifo_level, 0);
    chk("end_discard_locked", locked, 0);
    send(4'hA); send(4'h5);
    chk("end_relock", frame_start, 1);

    // Backpressure: 9 bytes into an 8-deep FIFO
    do_reset();
    byte_ready = 1'b0;
    send(4'hA); send(4'h5);
    for (int k = 0; k < 9; k++) begin send(4'hB); send(4'(k)); end
    chk("bp_level_8", fifo_level, 8);
    chk("bp_overflow", overflow, 1);
    chk("bp_head_b0", byte_out, 8'hB0);
    clr_overflow = 1'b1; idle(1); clr_overflow = 1'b0;
    chk("bp_clr", overflow, 0);

    // Full with simultaneous pop and push: 10th byte C9 closes the frame
    send(4'hC);
    byte_ready = 1'b1;
    send(4'h9);
    chk("fp_level_8", fifo_level, 8);
    chk("fp_overflow_0", overflow, 0);
    chk("fp_locked_0", locked, 0);
    for (int k = 0; k < 7; k++) exp_b[k] = 8'hB1 + 8'(k);
    exp_b[7] = 8'hC9;
    for (int k = 0; k < 8; k++) begin
      chk("fp_drain", byte_out, exp_b[k]);
      idle(1);
    end
    chk("fp_empty", byte_valid, 0);

    // Overflow clear race: a drop and a clear on the same edge leave overflow set
    byte_ready = 1'b0;
    send(4'hA); send(4'h5);
    for (int k = 0; k < 8; k++) begin send(4'hD); send(4'(k)); end
    chk("race_pre_ovf", overflow, 0);
    send(4'hD);
    clr_overflow = 1'b1;
    send(4'h8);
    chk("race_drop_wins", overflow, 1);
    idle(1);
    clr_overflow = 1'b0;
    chk("race_clr_alone", overflow, 0);

    // Async reset between the two nibbles of a byte
    send(4'hE);
    #2 rst = 1'b1;
    #1;
    chk("arst_byte_valid", byte_valid, 0);
    chk("arst_byte_out", byte_out, 8'h00);
    chk("arst_locked", locked, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_overflow", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(4'h5);
    chk("arst_5_no_lock", locked, 0);
    chk("arst_5_no_fs", frame_start, 0);

    // Randomized traffic, alternating sink readiness to exercise overflow and drain
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rdy_pct = ((c / 400) % 2 == 0) ? 85 : 25;
      r = int'($urandom_range(0, 9));
      sym_valid    = ($urandom_range(0, 9) < 7);
      sym_in       = (r < 3) ? 4'hA : (r < 6) ? 4'h5 : 4'($urandom());
      byte_ready   = (int'($urandom_range(0, 99)) < rdy_pct);
      clr_overflow = ($urandom_range(0, 39) == 0);
      rst          = ($urandom_range(0, 1499) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; sym_valid = 1'b0; clr_overflow = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
